// File: rtl/soc_system_cpu_debug_cmd_queue.sv
// Debug command queue: synchronizes vs_udr/vs_uir from the tck domain,
// queues {ir_in, sr} per update and pops into take_action/take_no_action.
// Ports: clk, reset (sync, active-high); ir_in, sr, vs_udr, vs_uir,
// cmd_ready, clr_overflow in; cmd_valid, jdo, cmd_ch, take_action,
// take_no_action, uir_pulse, level, overflow out.
module soc_system_cpu_debug_cmd_queue #(
  parameter int SR_W        = 38,
  parameter int IR_W        = 2,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int ACT_BIT     = 34,
  parameter int UIR_FLUSH   = 1,
  localparam int N_CH = 2 ** IR_W,
  localparam int LW   = $clog2(DEPTH + 1),
  localparam int PW   = $clog2(DEPTH),
  localparam int FW   = $clog2(SYNC_STAGES + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [IR_W-1:0] ir_in,
  input  logic [SR_W-1:0] sr,
  input  logic            vs_udr,
  input  logic            vs_uir,
  input  logic            cmd_ready,
  input  logic            clr_overflow,
  output logic            cmd_valid,
  output logic [SR_W-1:0] jdo,
  output logic [IR_W-1:0] cmd_ch,
  output logic [N_CH-1:0] take_action,
  output logic [N_CH-1:0] take_no_action,
  output logic            uir_pulse,
  output logic [LW-1:0]   level,
  output logic            overflow
);

  typedef logic [IR_W+SR_W-1:0] ent_t;

  logic [SYNC_STAGES-1:0] udr_sync_q, uir_sync_q;
  logic                   udr_dly_q, uir_dly_q;
  logic                   udr_arm_q, uir_arm_q;
  logic [FW-1:0]          fill_q;
  logic [PW-1:0]          rptr_q, rptr_d;
  logic [PW-1:0]          wptr_q, wptr_d;
  logic [LW-1:0]          level_q, level_d;
  logic                   ovf_q, ovf_d;
  logic [N_CH-1:0]        ta_q, ta_d;
  logic [N_CH-1:0]        tna_q, tna_d;
  logic                   uirp_q;
  ent_t                   mem_q [DEPTH];

  logic udr_last, uir_last, fill_done;
  logic udr_edge, uir_edge, flush;
  logic full, pop, push, drop;
  ent_t head;

  assign udr_last  = udr_sync_q[SYNC_STAGES-1];
  assign uir_last  = uir_sync_q[SYNC_STAGES-1];
  assign fill_done = (fill_q == FW'(SYNC_STAGES));

  // Edges count only once the synchronizer has seen the line low after
  // reset, so a level held high across reset release is not an update.
  assign udr_edge = udr_last & ~udr_dly_q & udr_arm_q;
  assign uir_edge = uir_last & ~uir_dly_q & uir_arm_q;
  assign flush    = uir_edge & (UIR_FLUSH != 0);

  assign head      = mem_q[rptr_q];
  assign cmd_valid = (level_q != '0);
  assign full      = (level_q == LW'(DEPTH));
  assign pop       = cmd_valid & cmd_ready & ~flush;
  assign drop      = udr_edge & full & ~pop & ~flush;
  assign push      = udr_edge & ~drop;

  always_comb begin
    rptr_d  = rptr_q;
    wptr_d  = wptr_q;
    level_d = level_q;
    ovf_d   = ovf_q;
    ta_d    = '0;
    tna_d   = '0;
    if (flush) begin
      rptr_d  = wptr_q;
      wptr_d  = wptr_q + PW'(push);
      level_d = LW'(push);
    end else begin
      rptr_d  = rptr_q + PW'(pop);
      wptr_d  = wptr_q + PW'(push);
      level_d = level_q + LW'(push) - LW'(pop);
    end
    if (drop)
      ovf_d = 1'b1;
    else if (clr_overflow)
      ovf_d = 1'b0;
    if (pop) begin
      if (head[ACT_BIT])
        ta_d[head[SR_W+IR_W-1:SR_W]] = 1'b1;
      else
        tna_d[head[SR_W+IR_W-1:SR_W]] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      udr_sync_q <= '0;
      uir_sync_q <= '0;
      udr_dly_q  <= 1'b0;
      uir_dly_q  <= 1'b0;
      udr_arm_q  <= 1'b0;
      uir_arm_q  <= 1'b0;
      fill_q     <= '0;
      rptr_q     <= '0;
      wptr_q     <= '0;
      level_q    <= '0;
      ovf_q      <= 1'b0;
      ta_q       <= '0;
      tna_q      <= '0;
      uirp_q     <= 1'b0;
    end else begin
      udr_sync_q <= {udr_sync_q[SYNC_STAGES-2:0], vs_udr};
      uir_sync_q <= {uir_sync_q[SYNC_STAGES-2:0], vs_uir};
      udr_dly_q  <= udr_last;
      uir_dly_q  <= uir_last;
      if (!fill_done)
        fill_q <= fill_q + FW'(1);
      if (fill_done && !udr_last)
        udr_arm_q <= 1'b1;
      if (fill_done && !uir_last)
        uir_arm_q <= 1'b1;
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      level_q <= level_d;
      ovf_q   <= ovf_d;
      ta_q    <= ta_d;
      tna_q   <= tna_d;
      uirp_q  <= uir_edge;
    end
  end

  // Storage needs no reset: entries are only visible through level_q.
  always_ff @(posedge clk) begin
    if (push)
      mem_q[wptr_q] <= {ir_in, sr};
  end

  assign jdo            = cmd_valid ? head[SR_W-1:0] : '0;
  assign cmd_ch         = cmd_valid ? head[SR_W+IR_W-1:SR_W] : '0;
  assign take_action    = ta_q;
  assign take_no_action = tna_q;
  assign uir_pulse      = uirp_q;
  assign level          = level_q;
  assign overflow       = ovf_q;

endmodule

// File: tb/tb_soc_system_cpu_debug_cmd_queue.sv
// Randomized scoreboard bench for the debug command queue, two instances
// (flush on vs_uir enabled and disabled) against a queue-level model.
module tb_soc_system_cpu_debug_cmd_queue;

  localparam int SR_W  = 38;
  localparam int IR_W  = 2;
  localparam int DEPTH = 4;
  localparam int SYNC  = 2;
  localparam int ACT   = 34;
  localparam int N_CH  = 4;
  localparam int LW    = 3;

  typedef logic [IR_W+SR_W-1:0] ent_t;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [IR_W-1:0] ir_in = '0;
  logic [SR_W-1:0] sr = '0;
  logic            vs_udr = 1'b0;
  logic            vs_uir = 1'b0;
  logic            cmd_ready = 1'b0;
  logic            clr_overflow = 1'b0;

  logic            cv [2];
  logic [SR_W-1:0] jdo [2];
  logic [IR_W-1:0] ch [2];
  logic [N_CH-1:0] ta [2];
  logic [N_CH-1:0] tna [2];
  logic            up [2];
  logic [LW-1:0]   lvl [2];
  logic            ovf [2];

  int checks = 0;
  int failures = 0;

  ent_t mq [2][$];
  ent_t eq [2][$];
  bit   m_ovf [2];
  bit   m_uir = 1'b0;
  bit   dq [$];
  bit   uq [$];
  bit   mon_en = 1'b0;
  bit   rnd_en = 1'b0;
  int   rdy_mod = 2;

  always #5 clk = ~clk;

  soc_system_cpu_debug_cmd_queue #(
    .SR_W(SR_W), .IR_W(IR_W), .DEPTH(DEPTH),
    .SYNC_STAGES(SYNC), .ACT_BIT(ACT), .UIR_FLUSH(1)
  ) u_dut0 (
    .clk(clk), .reset(reset), .ir_in(ir_in), .sr(sr),
    .vs_udr(vs_udr), .vs_uir(vs_uir), .cmd_ready(cmd_ready),
    .clr_overflow(clr_overflow), .cmd_valid(cv[0]), .jdo(jdo[0]),
    .cmd_ch(ch[0]), .take_action(ta[0]), .take_no_action(tna[0]),
    .uir_pulse(up[0]), .level(lvl[0]), .overflow(ovf[0])
  );

  soc_system_cpu_debug_cmd_queue #(
    .SR_W(SR_W), .IR_W(IR_W), .DEPTH(DEPTH),
    .SYNC_STAGES(SYNC), .ACT_BIT(ACT), .UIR_FLUSH(0)
  ) u_dut1 (
    .clk(clk), .reset(reset), .ir_in(ir_in), .sr(sr),
    .vs_udr(vs_udr), .vs_uir(vs_uir), .cmd_ready(cmd_ready),
    .clr_overflow(clr_overflow), .cmd_valid(cv[1]), .jdo(jdo[1]),
    .cmd_ch(ch[1]), .take_action(ta[1]), .take_no_action(tna[1]),
    .uir_pulse(up[1]), .level(lvl[1]), .overflow(ovf[1])
  );

  task automatic chk(input string nm, input int i,
                     input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s[%0d] t=%0t got=%0h exp=%0h", nm, i, $time, got, exp);
    end
  endtask

  // Reference model: an update is the first high sample after a low one,
  // taking effect SYNC edges after that sample; both samples must be
  // taken after the last reset edge.
  task automatic model_step();
    bit de, ue, fl, pp, dr;
    int n;
    if (reset) begin
      dq.delete();
      uq.delete();
      for (int i = 0; i < 2; i++) begin
        mq[i].delete();
        m_ovf[i] = 1'b0;
      end
      m_uir = 1'b0;
      return;
    end
    dq.push_back(vs_udr);
    uq.push_back(vs_uir);
    if (dq.size() > SYNC + 3) dq.pop_front();
    if (uq.size() > SYNC + 3) uq.pop_front();
    n = dq.size();
    de = (n >= SYNC + 2) && dq[n-1-SYNC] && !dq[n-2-SYNC];
    ue = (n >= SYNC + 2) && uq[n-1-SYNC] && !uq[n-2-SYNC];
    for (int i = 0; i < 2; i++) begin
      fl = ue && (i == 0);
      pp = !fl && (mq[i].size() > 0) && cmd_ready;
      dr = 1'b0;
      if (pp) eq[i].push_back(mq[i][0]);
      if (fl) begin
        mq[i].delete();
        if (de) mq[i].push_back({ir_in, sr});
      end else begin
        if (pp) void'(mq[i].pop_front());
        if (de) begin
          if (mq[i].size() < DEPTH) mq[i].push_back({ir_in, sr});
          else dr = 1'b1;
        end
      end
      if (dr) m_ovf[i] = 1'b1;
      else if (clr_overflow) m_ovf[i] = 1'b0;
    end
    m_uir = ue;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Monitor: compare visible state every cycle; pop the scoreboard
  // whenever a take pulse appears.
  initial forever begin
    @(negedge clk);
    if (mon_en) begin
      for (int i = 0; i < 2; i++) begin
        ent_t e;
        logic [N_CH-1:0] oh;
        chk("level", i, 64'(lvl[i]), 64'(mq[i].size()));
        chk("cmd_valid", i, 64'(cv[i]), 64'(mq[i].size() > 0));
        chk("overflow", i, 64'(ovf[i]), 64'(m_ovf[i]));
        chk("uir_pulse", i, 64'(up[i]), 64'(m_uir));
        if (mq[i].size() > 0) begin
          e = mq[i][0];
          chk("jdo", i, 64'(jdo[i]), 64'(e[SR_W-1:0]));
          chk("cmd_ch", i, 64'(ch[i]), 64'(e[SR_W+IR_W-1:SR_W]));
        end else begin
          chk("jdo_idle", i, 64'(jdo[i]), 64'd0);
          chk("cmd_ch_idle", i, 64'(ch[i]), 64'd0);
        end
        if ((ta[i] | tna[i]) != '0) begin
          if (eq[i].size() == 0) begin
            chk("spurious_pulse", i, 64'({ta[i], tna[i]}), 64'd0);
          end else begin
            e = eq[i].pop_front();
            oh = '0;
            oh[e[SR_W+IR_W-1:SR_W]] = 1'b1;
            chk("take_action", i, 64'(ta[i]), 64'(e[ACT] ? oh : '0));
            chk("take_no_action", i, 64'(tna[i]), 64'(e[ACT] ? '0 : oh));
          end
        end
        if (eq[i].size() != 0) begin
          chk("missing_pulse", i, 64'd0, 64'(eq[i].size()));
          eq[i].delete();
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (rnd_en) begin
        cmd_ready    = ($urandom % rdy_mod) == 0;
        clr_overflow = ($urandom % 8) == 0;
      end
    end
  endtask

  function automatic logic [SR_W-1:0] mk_sr(input bit act, input logic [7:0] lo);
    logic [SR_W-1:0] s;
    s = SR_W'({$urandom, $urandom});
    s[ACT] = act;
    s[7:0] = lo;
    return s;
  endfunction

  task automatic udr(input logic [IR_W-1:0] i, input logic [SR_W-1:0] s,
                     input int hi, input int lo, input bit with_uir);
    ir_in  = i;
    sr     = s;
    vs_udr = 1'b1;
    vs_uir = with_uir;
    step(hi);
    vs_udr = 1'b0;
    vs_uir = 1'b0;
    step(lo);
  endtask

  task automatic uir();
    vs_uir = 1'b1;
    step(SYNC + 2);
    vs_uir = 1'b0;
    step(SYNC + 2);
  endtask

  task automatic rnd_udr();
    udr(IR_W'($urandom), mk_sr($urandom % 2 == 1, 8'($urandom)),
        SYNC + 1 + int'($urandom % 3), SYNC + 1 + int'($urandom % 3), 1'b0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog t=%0t got=timeout exp=finish", $time);
    $fatal(1);
  end

  initial begin
    step(1);
    mon_en = 1'b1;
    step(2);
    reset = 1'b0;
    step(4);

    // single action update, ready held
    cmd_ready = 1'b1;
    udr(2'd2, mk_sr(1'b1, 8'hA5), SYNC + 2, SYNC + 2, 1'b0);
    step(3);

    // fill past depth, then drain and clear overflow
    cmd_ready = 1'b0;
    repeat (5) rnd_udr();
    step(2);
    cmd_ready = 1'b1;
    step(8);
    cmd_ready = 1'b0;
    clr_overflow = 1'b1;
    step(1);
    clr_overflow = 1'b0;
    step(2);

    // full queue, update edge coincident with a pop
    repeat (4) rnd_udr();
    ir_in  = 2'd3;
    sr     = mk_sr(1'b0, 8'h3C);
    vs_udr = 1'b1;
    step(SYNC);
    cmd_ready = 1'b1;
    step(1);
    cmd_ready = 1'b0;
    step(SYNC + 1);
    vs_udr = 1'b0;
    step(SYNC + 2);
    cmd_ready = 1'b1;
    step(8);

    // flush with three queued entries
    cmd_ready = 1'b0;
    repeat (3) rnd_udr();
    uir();
    step(2);
    cmd_ready = 1'b1;
    step(8);

    // no-action path
    udr(2'd1, mk_sr(1'b0, 8'h11), SYNC + 2, SYNC + 2, 1'b0);

    // reset mid-queue
    cmd_ready = 1'b0;
    repeat (2) rnd_udr();
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    step(4);

    // vs_udr held high through reset release
    vs_udr = 1'b1;
    step(SYNC + 2);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    step(6);
    vs_udr = 1'b0;
    step(SYNC + 2);
    cmd_ready = 1'b1;
    rnd_udr();
    step(3);

    // randomized traffic, slow then fast consumer
    rnd_en = 1'b1;
    for (int k = 0; k < 300; k++) begin
      int r;
      rdy_mod = (k < 150) ? 6 : 2;
      r = int'($urandom % 10);
      if (r < 6) rnd_udr();
      else if (r == 6) uir();
      else if (r == 7)
        udr(IR_W'($urandom), mk_sr($urandom % 2 == 1, 8'($urandom)),
            SYNC + 2, SYNC + 2, 1'b1);
      else step(1 + int'($urandom % 4));
    end
    rnd_en = 1'b0;
    cmd_ready = 1'b1;
    clr_overflow = 1'b0;
    step(12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
